regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined core. It provides NRD

---
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD bypassed combinational reads, two write ports (port 1 wins),
// per-entry busy scoreboard, and a clear sequencer that zeroes the array after reset.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    bsy_set_en,
  input  logic [ADDR_W-1:0]       bsy_set_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wr0_ok, wr1_ok, bsy_ok;
  logic [ADDR_W-1:0]   ra;

  // Effective write/reserve strobes: only in RUN, and never to a hardwired-zero entry 0.
  assign wr0_ok = (state_q == RUN) && wr0_en && !(ZERO_REG && wr0_addr == '0);
  assign wr1_ok = (state_q == RUN) && wr1_en && !(ZERO_REG && wr1_addr == '0);
  assign bsy_ok = (state_q == RUN) && bsy_set_en && !(ZERO_REG && bsy_set_addr == '0);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    mem_d     = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_cnt_q] = '0;
      clr_cnt_d        = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end else begin
      if (wr0_ok) begin
        mem_d[wr0_addr]  = wr0_data;
        busy_d[wr0_addr] = 1'b0;
      end
      if (wr1_ok) begin
        mem_d[wr1_addr]  = wr1_data;
        busy_d[wr1_addr] = 1'b0;
      end
      // A new reservation outranks a retiring write to the same entry.
      if (bsy_ok) busy_d[bsy_set_addr] = 1'b1;
    end
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (state_q == RUN) begin
        if (ZERO_REG && ra == '0)           rd_data[i*DATA_W +: DATA_W] = '0;
        else if (wr1_ok && wr1_addr == ra)  rd_data[i*DATA_W +: DATA_W] = wr1_data;
        else if (wr0_ok && wr0_addr == ra)  rd_data[i*DATA_W +: DATA_W] = wr0_data;
        else                                rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
        rd_busy[i] = busy_q[ra] & ~((wr0_ok && wr0_addr == ra) || (wr1_ok && wr1_addr == ra));
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two 4-read-port instances (entry 0 hardwired / ordinary) share stimulus.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_a [4];
  logic [19:0] rd_addr;
  logic        wr0_en, wr1_en, bsy_set_en;
  logic [4:0]  wr0_addr, wr1_addr, bsy_set_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        ready_z, ready_nz;
  logic [127:0] rd_data_z, rd_data_nz;
  logic [3:0]  rd_busy_z, rd_busy_nz;

  typedef struct {
    string       name;
    int          port;
    bit          nz;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t sb [$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  assign rd_addr = {rd_a[3], rd_a[2], rd_a[1], rd_a[0]};

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .ready(ready_z),
    .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .ready(ready_nz),
    .rd_addr(rd_addr), .rd_data(rd_data_nz), .rd_busy(rd_busy_nz),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr)
  );

  function automatic logic [31:0] got_data(int p, bit nz);
    return nz ? rd_data_nz[p*32 +: 32] : rd_data_z[p*32 +: 32];
  endfunction

  function automatic logic got_busy(int p, bit nz);
    return nz ? rd_busy_nz[p] : rd_busy_z[p];
  endfunction

  task automatic push(string name, int port, bit nz, logic [31:0] data, logic busy);
    exp_t e;
    e.name = name; e.port = port; e.nz = nz; e.data = data; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    bsy_set_en = 0; bsy_set_addr = '0;
  endtask

  task automatic drv0(logic [4:0] a, logic [31:0] d);
    wr0_en = 1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic drv1(logic [4:0] a, logic [31:0] d);
    wr1_en = 1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic bsy(logic [4:0] a);
    bsy_set_en = 1; bsy_set_addr = a;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1; idle();
    for (int p = 0; p < 4; p++) rd_a[p] = 5'(p);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 32; i++) begin
      total_cnt++;
      if (ready_z !== 1'b0 || ready_nz !== 1'b0)
        $display("FAIL reset_ready_low cycle %0d: got %b/%b expected 0/0", i, ready_z, ready_nz);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (ready_z !== 1'b1 || ready_nz !== 1'b1)
      $display("FAIL reset_ready_high: got %b/%b expected 1/1", ready_z, ready_nz);
    else pass_cnt++;
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        rd_a[p] = 5'(s*4 + p);
        push("reset_entry_zero", p, 0, 32'h0, 1'b0);
        push("reset_entry_zero", p, 1, 32'h0, 1'b0);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total_cnt++;
        if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
          $display("FAIL %s port%0d nz=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, e.nz, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1; idle();
      case (s)
        0: begin
          drv0(5, 32'hDEADBEEF); drv1(5, 32'h12345678); rd_a[0] = 5;
          push("dual_write_bypass", 0, 0, 32'h12345678, 0);
          push("dual_write_bypass", 0, 1, 32'h12345678, 0);
        end
        1: begin
          push("dual_write_stored", 0, 0, 32'h12345678, 0);
          push("dual_write_stored", 0, 1, 32'h12345678, 0);
        end
        2: begin
          drv0(6, 32'hAAAA0000); drv1(9, 32'hBBBB0000);
          rd_a[0] = 6; rd_a[1] = 9; rd_a[2] = 5; rd_a[3] = 0;
          push("wr0_bypass", 0, 0, 32'hAAAA0000, 0);
          push("wr1_bypass", 1, 0, 32'hBBBB0000, 0);
          push("array_read", 2, 0, 32'h12345678, 0);
          push("zero_read", 3, 0, 32'h0, 0);
        end
        default: begin
          push("wr0_stored", 0, 0, 32'hAAAA0000, 0);
          push("wr1_stored", 1, 1, 32'hBBBB0000, 0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total_cnt++;
        if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
          $display("FAIL %s port%0d nz=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, e.nz, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1; idle();
      rd_a[0] = 0;
      case (s)
        0: begin
          drv0(0, 32'hFFFFFFFF);
          push("r0_write_same_cycle", 0, 0, 32'h0, 0);
          push("r0_write_same_cycle", 0, 1, 32'hFFFFFFFF, 0);
        end
        1: begin
          push("r0_write_next_cycle", 0, 0, 32'h0, 0);
          push("r0_write_next_cycle", 0, 1, 32'hFFFFFFFF, 0);
        end
        2: begin
          bsy(0);
          push("r0_reserve_same_cycle", 0, 0, 32'h0, 0);
          push("r0_reserve_same_cycle", 0, 1, 32'hFFFFFFFF, 0);
        end
        3: begin
          push("r0_reserve_next_cycle", 0, 0, 32'h0, 0);
          push("r0_reserve_next_cycle", 0, 1, 32'hFFFFFFFF, 1);
        end
        4: begin
          drv1(0, 32'h0);
          push("r0_retire", 0, 0, 32'h0, 0);
          push("r0_retire", 0, 1, 32'h0, 0);
        end
        default: begin
          push("r0_after_retire", 0, 0, 32'h0, 0);
          push("r0_after_retire", 0, 1, 32'h0, 0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total_cnt++;
        if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
          $display("FAIL %s port%0d nz=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, e.nz, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_busy();
    exp_t e;
    logic [31:0] ed [8];
    logic        eb [8];
    ed = '{32'h0, 32'h0, 32'hA5, 32'hA5, 32'h77, 32'h77, 32'h78, 32'h78};
    eb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1; idle();
      rd_a[0] = 7;
      case (s)
        0: bsy(7);
        2: drv0(7, 32'hA5);
        4: begin bsy(7); drv1(7, 32'h77); end
        6: drv0(7, 32'h78);
        default: ;
      endcase
      push("busy_r7", 0, 0, ed[s], eb[s]);
      push("busy_r7", 0, 1, ed[s], eb[s]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total_cnt++;
        if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
          $display("FAIL %s step%0d nz=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, s, e.nz, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_nrd4();
    exp_t e;
    logic [31:0] v [4];
    v = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1; idle();
      for (int p = 0; p < 4; p++) rd_a[p] = 5'(p + 1);
      if (s == 0) begin drv0(1, v[0]); drv1(2, v[1]); end
      if (s == 1) begin drv0(3, v[2]); drv1(4, v[3]); end
      for (int p = 0; p < 4; p++) begin
        push("four_port_read", p, 0, (s == 0 && p >= 2) ? 32'h0 : v[p], 0);
        push("four_port_read", p, 1, (s == 0 && p >= 2) ? 32'h0 : v[p], 0);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total_cnt++;
        if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
          $display("FAIL %s step%0d port%0d nz=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, s, e.port, e.nz, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_clear_restart();
    exp_t e;
    @(negedge clk);
    rst = 1; idle(); @(negedge clk); rst = 0;
    drv0(3, 32'h33333333); drv1(4, 32'h44444444); bsy(4);
    rd_a[0] = 3; rd_a[1] = 4; rd_a[2] = 5; rd_a[3] = 7;
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (ready_z !== 1'b0) $display("FAIL clear_ready_low cycle %0d: got %b expected 0", i, ready_z);
      else pass_cnt++;
      for (int p = 0; p < 4; p++) push("clear_reads_zero", p, 0, 32'h0, 0);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total_cnt++;
        if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
          $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    rst = 1; @(negedge clk); rst = 0;
    for (int i = 0; i < 32; i++) begin
      total_cnt++;
      if (ready_z !== 1'b0 || ready_nz !== 1'b0)
        $display("FAIL restart_ready_low cycle %0d: got %b/%b expected 0/0", i, ready_z, ready_nz);
      else pass_cnt++;
      @(negedge clk);
    end
    idle(); #1;
    total_cnt++;
    if (ready_z !== 1'b1 || ready_nz !== 1'b1)
      $display("FAIL restart_ready_high: got %b/%b expected 1/1", ready_z, ready_nz);
    else pass_cnt++;
    for (int p = 0; p < 4; p++) begin
      push("no_trace_after_clear", p, 0, 32'h0, 0);
      push("no_trace_after_clear", p, 1, 32'h0, 0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total_cnt++;
      if (got_data(e.port, e.nz) !== e.data || got_busy(e.port, e.nz) !== e.busy)
        $display("FAIL %s port%0d nz=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, e.port, e.nz, got_data(e.port, e.nz), got_busy(e.port, e.nz), e.data, e.busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    for (int p = 0; p < 4; p++) rd_a[p] = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_busy();
    test_nrd4();
    test_clear_restart();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
